// File: rtl/axo_mem_sram.sv
// Single-port word-organised SRAM bus slave with configurable wait states, size/alignment checks and byte lanes.
// Define AXO_MEM_SRAM_UNALIGNED_EN to accept misaligned accesses that stay inside one 32-bit word.

`ifndef AXO_MEM_EALIGN
`define AXO_MEM_EALIGN 32'h0000_0001
`endif
`ifndef AXO_MEM_EASIZE
`define AXO_MEM_EASIZE 32'h0000_0002
`endif

module axo_mem_sram #(
  parameter int WORDS       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  asize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error
);

  localparam int AW = $clog2(WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_we_q, req_we_d;
  logic [1:0]      req_size_q, req_size_d;
  logic [AW+1:0]   req_addr_q, req_addr_d;
  logic [31:0]     req_wdata_q, req_wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;

  logic [31:0]     mem [WORDS];

  logic            cur_we;
  logic [1:0]      cur_size;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_wdata;
  logic [1:0]      off;
  logic [AW-1:0]   widx;
  logic            size_err;
  logic            align_err;
  logic [3:0]      be_base;
  logic [3:0]      be;
  logic [31:0]     rd_mask;
  logic [31:0]     wdata_sh;
  logic [31:0]     rd_sh;
  logic            go_resp;
  logic            mem_we;
  logic            unused_addr_hi;

  // The crossbar has already decoded the range; the high address bits carry no information here.
  assign unused_addr_hi = ^addr[31:AW+2];

  // In IDLE the live bus request is decoded so a zero-wait response can be built in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    cur_we    = req_we_q;
    cur_size  = req_size_q;
    cur_addr  = req_addr_q;
    cur_wdata = req_wdata_q;
    if (state_q == S_IDLE) begin
      cur_we    = we;
      cur_size  = asize;
      cur_addr  = addr[AW+1:0];
      cur_wdata = wdata;
    end

    off      = cur_addr[1:0];
    widx     = cur_addr[AW+1:2];
    size_err = (cur_size == 2'd3);
`ifdef AXO_MEM_SRAM_UNALIGNED_EN
    align_err = ((cur_size == 2'd1) && (off == 2'd3)) ||
                ((cur_size == 2'd2) && (off != 2'd0));
`else
    align_err = ((cur_size == 2'd1) && off[0]) ||
                ((cur_size == 2'd2) && (off != 2'd0));
`endif

    case (cur_size)
      2'd0:    begin be_base = 4'b0001; rd_mask = 32'h0000_00ff; end
      2'd1:    begin be_base = 4'b0011; rd_mask = 32'h0000_ffff; end
      default: begin be_base = 4'b1111; rd_mask = 32'hffff_ffff; end
    endcase

    be       = be_base << off;
    wdata_sh = cur_wdata << {off, 3'b000};
    rd_sh    = (mem[widx] >> {off, 3'b000}) & rd_mask;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    go_resp     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (re || we) begin
          req_we_d    = we;
          req_size_d  = asize;
          req_addr_d  = addr[AW+1:0];
          req_wdata_d = wdata;
          if (WAIT_STATES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A master that withdraws its request mid-wait gets neither a response nor a write.
        if (!(re || we)) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (go_resp) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      error_d = size_err || align_err;
      if (size_err)       rdata_d = `AXO_MEM_EASIZE;
      else if (align_err) rdata_d = `AXO_MEM_EALIGN;
      else                rdata_d = rd_sh;
    end

    mem_we = go_resp && cur_we && !size_err && !align_err && !rst;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_we_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // NOTE: the array has no reset so it maps onto a RAM macro; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign error = error_q;

endmodule

// File: tb/tb_axo_mem_sram.sv
// Directed self-checking bench for axo_mem_sram: three instances with 0, 3 and 4 wait states.

`ifndef AXO_MEM_EALIGN
`define AXO_MEM_EALIGN 32'h0000_0001
`endif
`ifndef AXO_MEM_EASIZE
`define AXO_MEM_EASIZE 32'h0000_0002
`endif

module tb_axo_mem_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_v    [3];
  logic        we_v    [3];
  logic [1:0]  sz_v    [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_v [3];
  logic        ready_v [3];
  logic        error_v [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axo_mem_sram #(.WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .re(re_v[0]), .we(we_v[0]), .asize(sz_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]),
    .ready(ready_v[0]), .error(error_v[0]));

  axo_mem_sram #(.WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .re(re_v[1]), .we(we_v[1]), .asize(sz_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]),
    .ready(ready_v[1]), .error(error_v[1]));

  axo_mem_sram #(.WORDS(256), .WAIT_STATES(4)) u_ws4 (
    .clk(clk), .rst(rst), .re(re_v[2]), .we(we_v[2]), .asize(sz_v[2]),
    .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata_v[2]),
    .ready(ready_v[2]), .error(error_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on instance d, issued while it is idle; returns to idle before exiting.
  task automatic xact(input string tag, input int d, input logic r, input logic w,
                      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] dat,
                      input logic chk_rd, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_lat);
    logic [31:0] rd = 32'd0;
    logic        er = 1'b0;
    int          lat = 0;
    logic        got = 1'b0;
    re_v[d] = r; we_v[d] = w; sz_v[d] = sz; addr_v[d] = a; wdata_v[d] = dat;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (ready_v[d]) begin
        got = 1'b1; lat = i; rd = rdata_v[d]; er = error_v[d];
      end
    end
    re_v[d] = 1'b0; we_v[d] = 1'b0;
    check({tag, " ready_seen"}, {31'd0, got}, 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " error"}, {31'd0, er}, {31'd0, exp_err});
    if (chk_rd) check({tag, " rdata"}, rd, exp_rd);
    @(posedge clk); #1;
    check({tag, " ready_width"}, {31'd0, ready_v[d]}, 32'd0);
  endtask

  // Hold a read request continuously and measure the spacing of two ready pulses.
  task automatic b2b(input string tag, input int d, input int exp_gap);
    int cyc = 0;
    int t1 = -1;
    int t2 = -1;
    re_v[d] = 1'b1; we_v[d] = 1'b0; sz_v[d] = 2'd2; addr_v[d] = 32'h10;
    while (t2 < 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (ready_v[d]) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
    end
    re_v[d] = 1'b0;
    @(posedge clk); #1;
    check(tag, 32'(t2 - t1), 32'(exp_gap));
  endtask

  task automatic watch_no_ready(input string tag, input int d);
    logic seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_v[d]) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      re_v[i] = 1'b0; we_v[i] = 1'b0; sz_v[i] = 2'd0; addr_v[i] = 32'd0; wdata_v[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready[%0d]", i), {31'd0, ready_v[i]}, 32'd0);
      check($sformatf("reset error[%0d]", i), {31'd0, error_v[i]}, 32'd0);
      check($sformatf("reset rdata[%0d]", i), rdata_v[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: word write then read, read-and-write returns the old word.
    xact("ws0 wr word",  0, 1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 1);
    xact("ws0 rd word",  0, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1);
    xact("ws0 rw word",  0, 1'b1, 1'b1, 2'd2, 32'h10, 32'h01020304, 1'b1, 32'hDEADBEEF, 1'b0, 1);
    xact("ws0 rd after", 0, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'h01020304, 1'b0, 1);

    // Address wrap: index 0x100 folds onto word 0.
    xact("ws0 wr wrap",  0, 1'b0, 1'b1, 2'd2, 32'h400, 32'h5A5A1234, 1'b0, 32'd0, 1'b0, 1);
    xact("ws0 rd wrap",  0, 1'b1, 1'b0, 2'd2, 32'h000, 32'd0, 1'b1, 32'h5A5A1234, 1'b0, 1);

    // Three wait states: byte lanes.
    xact("ws3 wr base",  1, 1'b0, 1'b1, 2'd2, 32'h10, 32'h11223344, 1'b0, 32'd0, 1'b0, 4);
    xact("ws3 wr byte3", 1, 1'b0, 1'b1, 2'd0, 32'h13, 32'h000000A5, 1'b0, 32'd0, 1'b0, 4);
    xact("ws3 rd word",  1, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'hA5223344, 1'b0, 4);
    xact("ws3 rd byte3", 1, 1'b1, 1'b0, 2'd0, 32'h13, 32'd0, 1'b1, 32'h000000A5, 1'b0, 4);
    xact("ws3 rd byte1", 1, 1'b1, 1'b0, 2'd0, 32'h11, 32'd0, 1'b1, 32'h00000033, 1'b0, 4);
    xact("ws3 rd half2", 1, 1'b1, 1'b0, 2'd1, 32'h12, 32'd0, 1'b1, 32'h0000A522, 1'b0, 4);

    // Misaligned half access.
`ifdef AXO_MEM_SRAM_UNALIGNED_EN
    xact("ws3 rd half1", 1, 1'b1, 1'b0, 2'd1, 32'h11, 32'd0, 1'b1, 32'h00002233, 1'b0, 4);
`else
    xact("ws3 rd half1", 1, 1'b1, 1'b0, 2'd1, 32'h11, 32'd0, 1'b1, `AXO_MEM_EALIGN, 1'b1, 4);
`endif
    xact("ws3 rd half3", 1, 1'b1, 1'b0, 2'd1, 32'h13, 32'd0, 1'b1, `AXO_MEM_EALIGN, 1'b1, 4);
    xact("ws3 wr half3", 1, 1'b0, 1'b1, 2'd1, 32'h13, 32'h0000FFFF, 1'b1, `AXO_MEM_EALIGN, 1'b1, 4);
    xact("ws3 wr word1", 1, 1'b0, 1'b1, 2'd2, 32'h11, 32'hFFFFFFFF, 1'b1, `AXO_MEM_EALIGN, 1'b1, 4);
    xact("ws3 rd keep1", 1, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'hA5223344, 1'b0, 4);

    // Half write on the upper lanes, then illegal size.
    xact("ws3 wr half2", 1, 1'b0, 1'b1, 2'd1, 32'h12, 32'h0000BEEF, 1'b0, 32'd0, 1'b0, 4);
    xact("ws3 rd half w",1, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'hBEEF3344, 1'b0, 4);
    xact("ws3 rd size3", 1, 1'b1, 1'b0, 2'd3, 32'h10, 32'd0, 1'b1, `AXO_MEM_EASIZE, 1'b1, 4);
    xact("ws3 wr size3", 1, 1'b0, 1'b1, 2'd3, 32'h10, 32'hFFFFFFFF, 1'b1, `AXO_MEM_EASIZE, 1'b1, 4);
    xact("ws3 rd keep3", 1, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0, 1'b1, 32'hBEEF3344, 1'b0, 4);

    // Four wait states: reset during a write, then an aborted write.
    xact("ws4 wr old",   2, 1'b0, 1'b1, 2'd2, 32'h20, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0, 5);

    re_v[2] = 1'b0; we_v[2] = 1'b1; sz_v[2] = 2'd2; addr_v[2] = 32'h20; wdata_v[2] = 32'h12345678;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; we_v[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ws4 rst ready", {31'd0, ready_v[2]}, 32'd0);
    check("ws4 rst error", {31'd0, error_v[2]}, 32'd0);
    check("ws4 rst rdata", rdata_v[2], 32'd0);
    watch_no_ready("ws4 rst no_ready", 2);
    xact("ws4 rd after rst", 2, 1'b1, 1'b0, 2'd2, 32'h20, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0, 5);

    re_v[2] = 1'b0; we_v[2] = 1'b1; sz_v[2] = 2'd2; addr_v[2] = 32'h20; wdata_v[2] = 32'h0BAD0BAD;
    @(posedge clk);
    @(posedge clk); #1;
    we_v[2] = 1'b0;
    watch_no_ready("ws4 abort no_ready", 2);
    xact("ws4 rd after abort", 2, 1'b1, 1'b0, 2'd2, 32'h20, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0, 5);

    // Back-to-back: one IDLE cycle between responses.
    b2b("ws0 b2b gap", 0, 2);
    b2b("ws3 b2b gap", 1, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
